// File: rtl/bmem_arbiter_pkg.sv
// bmem_arbiter_pkg: shared types and constants for the burst memory arbiter
package bmem_arbiter_pkg;
    localparam int BMEM_BEATS  = 4;
    localparam int BMEM_BEAT_W = 64;
    localparam int BMEM_ADDR_W = 32;
    localparam int BMEM_LINE_W = BMEM_BEATS * BMEM_BEAT_W;

    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR, DONE} bmem_arb_state_t;
    typedef enum logic {REQ_I, REQ_D} requester_t;
endpackage

// File: rtl/bmem_arbiter_if.sv
// bmem_arbiter_if: icache/dcache line-miss ports plus the shared burst memory port
interface bmem_arbiter_if
    import bmem_arbiter_pkg::*;
#(
    parameter int BEATS  = BMEM_BEATS,
    parameter int BEAT_W = BMEM_BEAT_W,
    parameter int ADDR_W = BMEM_ADDR_W
);
    localparam int LINE_W = BEATS * BEAT_W;

    logic [ADDR_W-1:0] i_req_addr;
    logic              i_req_read;
    logic [LINE_W-1:0] i_resp_rdata;
    logic              i_resp_valid;
    logic [ADDR_W-1:0] d_req_addr;
    logic              d_req_read;
    logic              d_req_write;
    logic [LINE_W-1:0] d_req_wdata;
    logic [LINE_W-1:0] d_resp_rdata;
    logic              d_resp_valid;
    logic [ADDR_W-1:0] bmem_addr;
    logic              bmem_read;
    logic              bmem_write;
    logic [BEAT_W-1:0] bmem_wdata;
    logic              bmem_ready;
    logic [ADDR_W-1:0] bmem_raddr;
    logic [BEAT_W-1:0] bmem_rdata;
    logic              bmem_rvalid;

    modport slave (
        input  i_req_addr, i_req_read, d_req_addr, d_req_read, d_req_write, d_req_wdata,
               bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
        output i_resp_rdata, i_resp_valid, d_resp_rdata, d_resp_valid,
               bmem_addr, bmem_read, bmem_write, bmem_wdata
    );

    modport master (
        output i_req_addr, i_req_read, d_req_addr, d_req_read, d_req_write, d_req_wdata,
               bmem_ready, bmem_raddr, bmem_rdata, bmem_rvalid,
        input  i_resp_rdata, i_resp_valid, d_resp_rdata, d_resp_valid,
               bmem_addr, bmem_read, bmem_write, bmem_wdata
    );
endinterface

// File: rtl/bmem_arbiter.sv
// bmem_arbiter: round-robin sharing of one 4-beat burst memory port between icache and dcache
module bmem_arbiter
    import bmem_arbiter_pkg::*;
#(
    parameter int BEATS  = BMEM_BEATS,
    parameter int BEAT_W = BMEM_BEAT_W,
    parameter int ADDR_W = BMEM_ADDR_W
) (
    input logic           clk,
    input logic           rst,
    bmem_arbiter_if.slave bus
);
    localparam int CNT_W = $clog2(BEATS);
    localparam int OFF_W = $clog2(BEATS * BEAT_W / 8);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(BEATS - 1);

    bmem_arb_state_t              r_state;
    requester_t                   r_last, r_win, w_win;
    logic [CNT_W-1:0]             r_cnt;
    logic [ADDR_W-1:0]            r_addr, w_sel, w_addr;
    logic [BEATS-1:0][BEAT_W-1:0] r_line, w_line;
    logic                         w_d_req, w_wr, w_hit;

    always_comb begin
        w_d_req = bus.d_req_read | bus.d_req_write;
        w_win = (w_d_req && (!bus.i_req_read || r_last == REQ_I)) ? REQ_D : REQ_I;
        w_wr = (w_win == REQ_D) && bus.d_req_write;
        w_sel = (w_win == REQ_D) ? bus.d_req_addr : bus.i_req_addr;
        w_addr = {w_sel[ADDR_W-1:OFF_W], OFF_W'(0)};
        w_hit = bus.bmem_rvalid && bus.bmem_raddr == r_addr;
        w_line = r_line;
        w_line[r_cnt] = bus.bmem_rdata;
    end

    // r_line doubles as the read assembly buffer and the latched writeback line
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= IDLE;
            r_last           <= REQ_I;
            r_win            <= REQ_I;
            r_cnt            <= '0;
            r_addr           <= '0;
            r_line           <= '0;
            bus.i_resp_rdata <= '0;
            bus.i_resp_valid <= 1'b0;
            bus.d_resp_rdata <= '0;
            bus.d_resp_valid <= 1'b0;
            bus.bmem_addr    <= '0;
            bus.bmem_read    <= 1'b0;
            bus.bmem_write   <= 1'b0;
            bus.bmem_wdata   <= '0;
        end else begin
            case (r_state)
                IDLE: if (bus.i_req_read || w_d_req) begin
                    r_win          <= w_win;
                    r_last         <= w_win;
                    r_addr         <= w_addr;
                    r_line         <= w_wr ? bus.d_req_wdata : '0;
                    bus.bmem_addr  <= w_addr;
                    bus.bmem_wdata <= bus.d_req_wdata[BEAT_W-1:0];
                    bus.bmem_write <= w_wr;
                    bus.bmem_read  <= !w_wr;
                    r_state        <= w_wr ? WR : RD_ISSUE;
                end
                RD_ISSUE: if (bus.bmem_ready) begin
                    bus.bmem_read <= 1'b0;
                    r_state       <= RD_WAIT;
                end
                RD_WAIT: if (w_hit) begin
                    r_line <= w_line;
                    r_cnt  <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        r_state          <= DONE;
                        bus.i_resp_valid <= r_win == REQ_I;
                        bus.d_resp_valid <= r_win == REQ_D;
                        if (r_win == REQ_I) bus.i_resp_rdata <= w_line;
                        else bus.d_resp_rdata <= w_line;
                    end
                end
                WR: if (bus.bmem_ready) begin
                    r_cnt          <= r_cnt + 1'b1;
                    bus.bmem_wdata <= r_line[r_cnt + 1'b1];
                    if (r_cnt == LAST) begin
                        r_state          <= DONE;
                        bus.bmem_write   <= 1'b0;
                        bus.d_resp_valid <= 1'b1;
                        bus.d_resp_rdata <= '0;
                    end
                end
                DONE: begin
                    bus.i_resp_valid <= 1'b0;
                    bus.d_resp_valid <= 1'b0;
                    r_cnt            <= '0;
                    r_state          <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    a_rw_exclusive_req: assert property (@(posedge clk) disable iff (rst) !(bus.d_req_read && bus.d_req_write));
    a_rw_exclusive_bus: assert property (@(posedge clk) disable iff (rst) !(bus.bmem_read && bus.bmem_write));
    c_stray_beat: cover property (@(posedge clk) disable iff (rst) bus.bmem_rvalid && r_state != RD_WAIT);
    c_foreign_beat: cover property (@(posedge clk) disable iff (rst) bus.bmem_rvalid && r_state == RD_WAIT && !w_hit);
endmodule

// File: tb/tb_bmem_arbiter.sv
// tb_bmem_arbiter: directed plus randomized transactions against a line-level arbitration model
module tb_bmem_arbiter;
    import bmem_arbiter_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int n_tests = 0;
    int n_fail = 0;
    bit last_d, fixed, stray, wrong, won;
    int stall_beat, stall_len, issue_wait, gap_max;
    logic [255:0] line;
    logic [31:0] a6;

    bmem_arbiter_if bus ();
    bmem_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    task automatic new_i();
        bus.i_req_read = 1'b1;
        bus.i_req_addr = $urandom;
    endtask

    task automatic new_d();
        bit wr;
        wr = $urandom_range(0, 1) == 1;
        bus.d_req_addr  = $urandom;
        bus.d_req_write = wr;
        bus.d_req_read  = !wr;
        for (int j = 0; j < 4; j++) bus.d_req_wdata[64*j +: 64] = rnd64();
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, "_i_valid"}, bus.i_resp_valid, 1'b0);
        chk({tag, "_d_valid"}, bus.d_resp_valid, 1'b0);
    endtask

    // Model: a lone requester wins, a tie goes to the side not granted last; lines are the beats in order
    task automatic serve(output bit won_d, output logic [255:0] exp_line);
        logic [63:0] beats [4];
        logic [31:0] a;
        int k, stall, cyc;
        bit wr, rdy;
        won_d = (bus.d_req_read || bus.d_req_write) && (!bus.i_req_read || !last_d);
        last_d = won_d;
        wr = won_d && bus.d_req_write;
        a = won_d ? bus.d_req_addr : bus.i_req_addr;
        a = a - (a % 32);
        if (wr) begin
            for (int j = 0; j < 4; j++) beats[j] = bus.d_req_wdata[64*j +: 64];
            exp_line = '0;
            tick();
            k = 0;
            stall = 0;
            cyc = 0;
            while (k < 4 && cyc < 64) begin
                chk("wr_write", bus.bmem_write, 1'b1);
                chk("wr_read", bus.bmem_read, 1'b0);
                chk("wr_addr", bus.bmem_addr, a);
                chk("wr_data", bus.bmem_wdata, beats[k]);
                chk_quiet("wr_busy");
                rdy = !(k == stall_beat && stall < stall_len);
                if (!rdy) stall++;
                bus.bmem_ready = rdy;
                tick();
                if (rdy) k++;
                cyc++;
            end
            chk("wr_beats", k, 4);
        end else begin
            for (int j = 0; j < 4; j++) beats[j] = fixed ? 64'h1111_1111_1111_1111 * 64'(j + 1) : rnd64();
            exp_line = {beats[3], beats[2], beats[1], beats[0]};
            bus.bmem_rvalid = stray;
            bus.bmem_raddr = a;
            bus.bmem_rdata = rnd64();
            tick();
            bus.bmem_rvalid = 1'b0;
            for (int c = 0; c <= issue_wait; c++) begin
                chk("rd_read", bus.bmem_read, 1'b1);
                chk("rd_write", bus.bmem_write, 1'b0);
                chk("rd_addr", bus.bmem_addr, a);
                bus.bmem_ready = (c == issue_wait);
                tick();
            end
            chk("rd_issued", bus.bmem_read, 1'b0);
            for (int j = 0; j < 4; j++) begin
                repeat ($urandom_range(0, gap_max)) begin
                    bus.bmem_rvalid = 1'b0;
                    tick();
                end
                if (wrong && j == 1) begin
                    bus.bmem_rvalid = 1'b1;
                    bus.bmem_raddr = a ^ 32'h0000_0100;
                    bus.bmem_rdata = rnd64();
                    tick();
                end
                bus.bmem_rvalid = 1'b1;
                bus.bmem_raddr = a;
                bus.bmem_rdata = beats[j];
                tick();
                if (j < 3) chk_quiet("rd_busy");
            end
            bus.bmem_rvalid = 1'b0;
            chk("rd_bus_done", {bus.bmem_read, bus.bmem_write}, 2'b00);
        end
        chk("resp_i_valid", bus.i_resp_valid, !won_d);
        chk("resp_d_valid", bus.d_resp_valid, won_d);
        chk("resp_line", won_d ? bus.d_resp_rdata : bus.i_resp_rdata, exp_line);
    endtask

    task automatic finish_txn(input bit won_d, input logic [255:0] exp_line, input bit renew);
        if (won_d) begin
            bus.d_req_read = 1'b0;
            bus.d_req_write = 1'b0;
            if (renew) new_d();
        end else begin
            bus.i_req_read = 1'b0;
            if (renew) new_i();
        end
        tick();
        chk_quiet("pulse_end");
        chk("rdata_hold", won_d ? bus.d_resp_rdata : bus.i_resp_rdata, exp_line);
        chk("bus_idle", {bus.bmem_read, bus.bmem_write}, 2'b00);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_i_valid"}, bus.i_resp_valid, 1'b0);
        chk({tag, "_d_valid"}, bus.d_resp_valid, 1'b0);
        chk({tag, "_i_rdata"}, bus.i_resp_rdata, '0);
        chk({tag, "_d_rdata"}, bus.d_resp_rdata, '0);
        chk({tag, "_addr"}, bus.bmem_addr, '0);
        chk({tag, "_read"}, bus.bmem_read, 1'b0);
        chk({tag, "_write"}, bus.bmem_write, 1'b0);
        chk({tag, "_wdata"}, bus.bmem_wdata, '0);
    endtask

    initial begin
        bus.i_req_addr = '0;
        bus.i_req_read = 1'b0;
        bus.d_req_addr = '0;
        bus.d_req_read = 1'b0;
        bus.d_req_write = 1'b0;
        bus.d_req_wdata = '0;
        bus.bmem_ready = 1'b0;
        bus.bmem_raddr = '0;
        bus.bmem_rdata = '0;
        bus.bmem_rvalid = 1'b0;
        {fixed, stray, wrong, last_d} = '0;
        {stall_beat, stall_len, issue_wait, gap_max} = '0;
        tick();
        tick();
        chk_reset("reset");
        rst = 1'b0;

        fixed = 1'b1;
        bus.i_req_read = 1'b1;
        bus.i_req_addr = 32'h0000_1234;
        serve(won, line);
        finish_txn(won, line, 1'b0);
        fixed = 1'b0;

        bus.d_req_addr = 32'h8000_0040;
        bus.d_req_write = 1'b1;
        bus.d_req_wdata = {64'hDDDD_0000_0000_000D, 64'hCCCC_0000_0000_000C,
                           64'hBBBB_0000_0000_000B, 64'hAAAA_0000_0000_000A};
        serve(won, line);
        finish_txn(won, line, 1'b0);

        rst = 1'b1;
        tick();
        rst = 1'b0;
        last_d = 1'b0;
        bus.i_req_read = 1'b1;
        bus.i_req_addr = $urandom;
        bus.d_req_read = 1'b1;
        bus.d_req_addr = $urandom;
        serve(won, line);
        finish_txn(won, line, 1'b1);
        serve(won, line);
        finish_txn(won, line, 1'b0);
        serve(won, line);
        finish_txn(won, line, 1'b0);

        stall_beat = 2;
        stall_len = 3;
        bus.d_req_addr = $urandom;
        bus.d_req_write = 1'b1;
        for (int j = 0; j < 4; j++) bus.d_req_wdata[64*j +: 64] = rnd64();
        serve(won, line);
        finish_txn(won, line, 1'b0);
        stall_len = 0;

        stray = 1'b1;
        wrong = 1'b1;
        gap_max = 1;
        new_i();
        serve(won, line);
        finish_txn(won, line, 1'b0);
        {stray, wrong} = '0;
        gap_max = 0;

        new_i();
        a6 = bus.i_req_addr - (bus.i_req_addr % 32);
        tick();
        bus.bmem_ready = 1'b1;
        tick();
        for (int j = 0; j < 2; j++) begin
            bus.bmem_rvalid = 1'b1;
            bus.bmem_raddr = a6;
            bus.bmem_rdata = rnd64();
            tick();
        end
        bus.bmem_rvalid = 1'b0;
        rst = 1'b1;
        tick();
        chk_reset("midburst");
        rst = 1'b0;
        last_d = 1'b0;
        serve(won, line);
        finish_txn(won, line, 1'b0);

        repeat (40) begin
            if (!(bus.i_req_read || bus.d_req_read || bus.d_req_write)) begin
                case ($urandom_range(0, 2))
                    0: new_i();
                    1: new_d();
                    default: begin
                        new_i();
                        new_d();
                    end
                endcase
            end
            stall_beat = $urandom_range(0, 3);
            stall_len = $urandom_range(0, 3);
            issue_wait = $urandom_range(0, 2);
            gap_max = $urandom_range(0, 2);
            stray = $urandom_range(0, 1) == 1;
            wrong = $urandom_range(0, 1) == 1;
            serve(won, line);
            finish_txn(won, line, $urandom_range(0, 3) != 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/bmem_arbiter.md
Name: bmem_arbiter

Overview:
- Shares the single burst memory port (bmem_*) between the instruction-cache miss path and the data-cache miss/writeback path inside cache_unit.
- Accepts whole-line requests from each cache and serializes them into 4-beat 64-bit bursts.
- Assembles read bursts back into 256-bit lines and returns a one-cycle response pulse to the winning requester.
- Round-robin fairness, so neither the fetch stage nor the memory stage can starve the other.

Parameters:
BEATS, 4, beats per cache line burst
BEAT_W, 64, bmem data width per beat
ADDR_W, 32, address width; line width LINE_W = BEATS*BEAT_W (localparam, 256)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
i_req_addr  in  32  icache line miss address
i_req_read  in  1  icache read request (level, held until i_resp_valid)
i_resp_rdata  out  256  assembled line for icache
i_resp_valid  out  1  one-cycle completion pulse to icache
d_req_addr  in  32  dcache line address
d_req_read  in  1  dcache fill request (level)
d_req_write  in  1  dcache writeback request (level)
d_req_wdata  in  256  dcache writeback line, beat k = bits [64k+63:64k]
d_resp_rdata  out  256  assembled line for dcache
d_resp_valid  out  1  one-cycle completion pulse for dcache read or write
bmem_addr  out  32  line-aligned address, {addr[31:5],5'b0}
bmem_read  out  1  read command
bmem_write  out  1  write beat valid
bmem_wdata  out  64  write beat data
bmem_ready  in  1  memory accepts command/beat this cycle
bmem_raddr  in  32  address tag of returning read beat
bmem_rdata  in  64  read beat data
bmem_rvalid  in  1  read beat valid

Behaviour:
- Reset: all outputs 0; FSM in IDLE; beat counter 0; last_grant = I, so dcache wins the first tie.
- Every response/bmem output is a function of registered state only. No combinational path from req inputs to outputs.
- FSM states and transitions:
  - IDLE: sample requests.
    - Only one side requesting: that side wins.
    - Both requesting: the side not equal to last_grant wins.
    - Winner's address is latched; for a dcache write, d_req_wdata is latched too. last_grant is updated.
    - Read goes to RD_ISSUE; write goes to WR.
  - RD_ISSUE: bmem_read=1, bmem_addr=latched line address. When bmem_ready=1, go to RD_WAIT; otherwise hold.
  - RD_WAIT: on each bmem_rvalid with bmem_raddr==latched address, store the beat at index cnt and increment cnt. After beat BEATS-1, go to DONE.
  - WR: bmem_write=1, bmem_addr=latched address, bmem_wdata=latched beat[cnt]. cnt increments only when bmem_ready=1. After beat BEATS-1 is accepted, go to DONE.
  - DONE: pulse the winner's resp_valid for exactly one cycle, drive resp_rdata with the assembled line (0 for writes), reset cnt, return to IDLE.
- Latency, with no memory backpressure:
  - Write seen at cycle t: beats at t+1..t+4, resp_valid at t+5.
  - Read seen at cycle t: bmem_read at t+1; resp_valid one cycle after the 4th rvalid.
- Requester contract:
  - Request must be low by the cycle after its resp_valid. A request still high then is a new request.
  - A requester dropping its request mid-transaction does not abort it; the burst completes and resp_valid still pulses.
- Both d_req_read and d_req_write high: treated as a write. Flagged by assertion.
- Ignored beats, each flagged by assertion:
  - rvalid outside RD_WAIT.
  - rvalid with mismatched raddr.
- bmem_read and bmem_write are never high in the same cycle. bmem_read is high only in RD_ISSUE.
- resp_rdata is held between pulses; only the DONE-cycle value is meaningful.
- Reset mid-burst: return to IDLE the next cycle and discard partial beats. No response pulse is emitted.
- cnt is $clog2(BEATS) bits and wraps to 0 in DONE.

Decomposition:
- rv32i_types (shared package) gets:
  - bmem_arb_state_t enum {IDLE, RD_ISSUE, RD_WAIT, WR, DONE}.
  - requester enum {REQ_I, REQ_D}.
  - Constants BMEM_BEATS=4, BMEM_BEAT_W=64.
- Single module; no sub-module is warranted.
- Instantiated inside cache_unit between the icache/dcache miss ports and the bmem_* top-level ports.

Test Plan:
- Icache read only at 0x0000_1234, bmem_ready=1, rvalid beats 0x11..,0x22..,0x33..,0x44.. at raddr 0x0000_1220 -> one bmem_read with addr 0x0000_1220; i_resp_rdata={0x44..,0x33..,0x22..,0x11..}; i_resp_valid single pulse; d_resp_valid stays 0.
- Dcache write 0x8000_0040, wdata beats A,B,C,D, bmem_ready=1 -> bmem_write high 4 consecutive cycles carrying A,B,C,D at addr 0x8000_0040; d_resp_valid 5 cycles after the request is sampled.
- Simultaneous i and d read after reset -> dcache serviced first. Both held again -> icache next, then dcache (strict alternation).
- Write with bmem_ready low on beat 2 for 3 cycles -> bmem_wdata holds beat 2 and cnt does not advance; all 4 beats delivered in order.
- Stray rvalid in IDLE, and a beat with wrong raddr in RD_WAIT -> both ignored; line assembles correctly from the valid beats only.
- rst asserted after 2 read beats -> all outputs 0 next cycle; a subsequent request completes with a fresh 4-beat assembly and no stale data.
